dff_skid_stage: RTL and testbench
=================================

// Module: dff_skid_stage
// PURPOSE
// - Registered valid/ready skid buffer directly downstream of the dff design stage.
// - Captures each dff output word, holds it under consumer backpressure and
//   loses no data. Fully registered: no combinational path from out_ready to in_ready.
// - 1-cycle forward latency, full throughput.
// PARAMETERS
// - WIDTH   8    data width of in_data/out_data
// - CNT_W   16   width of the statistics counters (used only with DFF_SKID_STATS_EN)
// PORTS
// - clk        in   1      single system clock, all logic on posedge
// - rst        in   1      synchronous reset, active-high
// - in_valid   in   1      upstream (dff stage) word valid
// - in_ready   out  1      stage can accept a word this cycle (registered)
// - in_data    in   WIDTH  upstream word
// - out_valid  out  1      out_data valid to consumer
// - out_ready  in   1      consumer accepts out_data this cycle
// - out_data   out  WIDTH  registered output word
// - xfer_cnt   out  CNT_W  output transfers counted (only with DFF_SKID_STATS_EN)
// - stall_cnt  out  CNT_W  backpressure cycles counted (only with DFF_SKID_STATS_EN)
// BEHAVIOUR
// - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
// - Storage: main register (drives out_data) plus one skid register.
// - Reset (rst=1 sampled at posedge): state=EMPTY, out_valid=0, in_ready=0,
//   out_data=0, skid cleared, counters=0.
// - in_ready rises on the first posedge after rst is sampled low.
// - FSM states: EMPTY (0 words), BUSY (main full), FULL (main+skid full).
//   - EMPTY: in_fire -> BUSY, main<=in_data.
//   - BUSY, in_fire & !out_fire -> FULL, skid<=in_data, in_ready<=0.
//   - BUSY, !in_fire & out_fire -> EMPTY.
//   - BUSY, in_fire & out_fire -> BUSY, main<=in_data (back-to-back streaming).
//   - FULL: out_fire -> BUSY, main<=skid, in_ready<=1; otherwise hold.
//     in_ready=0 in FULL, so no in_fire is possible.
// - out_valid=1 in BUSY/FULL, 0 in EMPTY. in_ready=1 in EMPTY/BUSY.
// - Latency: a word accepted at edge N is presented with out_valid=1 after edge N.
// - Ordering: strict FIFO, depth 2. No drop, no duplication.
// - out_data is stable while out_valid & !out_ready.
// - In EMPTY, out_data holds its last value and has no meaning.
// - in_valid while in_ready=0: ignored. Upstream must hold in_data until accepted.
// - Reset mid-operation: all buffered words are discarded. out_valid=0 after that edge.
// - X on in_data while in_valid=0 must not propagate to the registers.
// CONFIGURATION
// - Macro DFF_SKID_STATS_EN.
// - Defined: xfer_cnt and stall_cnt ports and counters are present.
//   - xfer_cnt increments on each out_fire.
//   - stall_cnt increments on each cycle with out_valid & !out_ready.
//   - Both saturate at 2**CNT_W-1 and clear on rst.
// - Undefined: both ports and the counter logic are absent. Datapath is identical.
// TESTING
// - Reset: rst=1 for 10 cycles, then 0.
//   -> out_valid=0 throughout; in_ready=0 until 1 cycle after release, then 1.
// - Stream: out_ready=1, send 0x01..0x10 back-to-back.
//   -> out_data 0x01..0x10 in order, 1-cycle latency, in_ready stays 1.
// - Backpressure: out_ready=0, send 0xA1,0xA2,0xA3.
//   -> 0xA1 and 0xA2 accepted, in_ready=0, 0xA3 held upstream.
//   -> on out_ready=1: outputs 0xA1, 0xA2, 0xA3 in order.
// - Drain at BUSY: one word 0x55 with out_ready toggling 0,0,1.
//   -> out_data=0x55 stable for 3 cycles, then out_valid=0.
// - Mid reset: state FULL (0x11,0x22), assert rst 1 cycle.
//   -> out_valid=0 next edge; 0x11/0x22 never appear afterwards.
// - Stats (DFF_SKID_STATS_EN, CNT_W=4): 20 transfers and 3 stall cycles.
//   -> xfer_cnt=15 (saturated), stall_cnt=3.

Source files
------------

// File: rtl/dff_skid_stage.sv
// dff_skid_stage
//   Registered valid/ready skid buffer placed directly after the dff stage.
//   It captures each upstream word, holds it while the consumer applies
//   backpressure, and keeps strict FIFO order with a depth of two words
//   (main register + skid register). It has one cycle of forward latency
//   and full throughput. in_ready is a flop, so there is no combinational
//   path from out_ready to in_ready.
//
// Optional feature: define DFF_SKID_STATS_EN to add the saturating
//   transfer/stall counters and their output ports.
//
// Parameters
//   WIDTH      data width of in_data / out_data
//   CNT_W      counter width (only used with DFF_SKID_STATS_EN)
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous reset, active-high
//   in_valid   upstream word valid
//   in_ready   stage can accept a word this cycle (registered)
//   in_data    upstream word
//   out_valid  out_data valid to consumer
//   out_ready  consumer accepts out_data this cycle
//   out_data   registered output word
//   xfer_cnt   output transfers, saturating (DFF_SKID_STATS_EN only)
//   stall_cnt  out_valid & !out_ready cycles, saturating (DFF_SKID_STATS_EN only)

module dff_skid_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef DFF_SKID_STATS_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;
  logic             in_fire;
  logic             out_fire;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_next   = BUSY;
          load_main_in = 1'b1;
        end
      end
      BUSY: begin
        if (in_fire && !out_fire) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (!in_fire && out_fire) begin
          state_next = EMPTY;
        end else if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end
      end
      FULL: begin
        // in_ready is low here, so only the output side can move.
        if (out_fire) begin
          state_next     = BUSY;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // in_ready is registered from the next state, so it rises one edge after
  // reset release and drops on the same edge that fills the skid register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != FULL);
    end
  end

  // Data registers load only on in_fire / skid move, so in_data is never
  // sampled while in_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

`ifdef DFF_SKID_STATS_EN
  logic [CNT_W-1:0] xfer_q;
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_q  <= '0;
      stall_q <= '0;
    end else begin
      if (out_fire && (xfer_q != '1)) begin
        xfer_q <= xfer_q + 1'b1;
      end
      if (out_valid && !out_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign xfer_cnt  = xfer_q;
  assign stall_cnt = stall_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_dff_skid_stage.sv
// Scoreboard bench for dff_skid_stage: the driver pushes each accepted word
// into exp_q, a negedge monitor pops and compares on every output transfer.
module tb_dff_skid_stage;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
`ifdef DFF_SKID_STATS_EN
  logic [CNT_W-1:0] xfer_cnt;
  logic [CNT_W-1:0] stall_cnt;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  dff_skid_stage #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef DFF_SKID_STATS_EN
    ,
    .xfer_cnt (xfer_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got 0x%0h expected no transfer", out_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL out_data: got 0x%0h expected 0x%0h", out_data, e);
        end
      end
    end
  end

  // Present d until accepted; leaves in_valid high. Called just after a posedge.
  task automatic send(input logic [WIDTH-1:0] d, output int unsigned waited);
    bit done;
    waited   = 0;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int unsigned i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(d);
        done = 1'b1;
        break;
      end
      waited++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no in_ready expected accept of 0x%0h", d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  task automatic drain();
    for (int unsigned i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin : timeout_guard
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w;
    int unsigned total;

    // Reset held 10 cycles.
    rst = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready_low", in_ready, 0);
    check("rel_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    check("rel_in_ready_high", in_ready, 1);

    // Stream 0x01..0x10 back-to-back.
    out_ready = 1'b1;
    total = 0;
    for (int unsigned i = 1; i <= 16; i++) begin
      send(WIDTH'(i), w);
      total += w;
      if (i == 1) begin
        check("lat_out_valid", out_valid, 1);
        check("lat_out_data", out_data, 8'h01);
      end
    end
    check("stream_no_stall", total, 0);
    check("stream_in_ready", in_ready, 1);
    idle();
    drain();

    // Backpressure.
    out_ready = 1'b0;
    send(8'hA1, w);
    send(8'hA2, w);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_data", out_data, 8'hA1);
    in_data = 8'hA3;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("bp_hold_in_ready", in_ready, 0);
    check("bp_hold_out_data", out_data, 8'hA1);
    check("bp_hold_out_valid", out_valid, 1);
    out_ready = 1'b1;
    send(8'hA3, w);
    check("bp_a3_wait", w, 1);
    idle();
    drain();

    // Drain at BUSY with out_ready 0,0,1.
    out_ready = 1'b0;
    send(8'h55, w);
    idle();
    for (int unsigned k = 0; k < 3; k++) begin
      out_ready = (k == 2);
      @(negedge clk);
      check("busy_valid", out_valid, 1);
      check("busy_data", out_data, 8'h55);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("busy_empty", out_valid, 0);
    check("busy_q", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Reset while FULL discards both words.
    out_ready = 1'b0;
    send(8'h11, w);
    send(8'h22, w);
    idle();
    check("full_in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_no_out", out_valid, 0);
      @(posedge clk);
      #1;
    end
    check("mid_rst_ready_back", in_ready, 1);
    send(8'h33, w);
    idle();
    drain();

`ifdef DFF_SKID_STATS_EN
    // Stats: 3 stall cycles then 20 transfers total; xfer saturates at 15.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("stats_rst_xfer", xfer_cnt, 0);
    check("stats_rst_stall", stall_cnt, 0);
    out_ready = 1'b0;
    send(8'hC0, w);
    idle();
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int unsigned i = 1; i <= 19; i++) begin
      send(8'hC0 + WIDTH'(i), w);
    end
    idle();
    drain();
    @(posedge clk);
    #1;
    check("stats_xfer_sat", xfer_cnt, 15);
    check("stats_stall", stall_cnt, 3);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
